// File: rtl/pulse_rate_ctrl.sv
// pulse_rate_ctrl: run/pause/idle tick generator with four selectable periods and a toggling clk_out
module pulse_rate_ctrl #(
  parameter int P0 = 25000000,
  parameter int P1 = 12500000,
  parameter int P2 = 5000000,
  parameter int P3 = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       acc,
  input  logic       start,
  input  logic       stop,
  output logic       tick,
  output logic       clk_out,
  output logic [1:0] level,
  output logic       running,
  output logic       paused
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_n;
  logic [25:0] cnt, cnt_n, period, step_cnt;
  logic acc_q, start_q, stop_q, acc_e, start_e, stop_e, term, tick_n, clk_out_n;
  assign acc_e    = acc & ~acc_q;
  assign start_e  = start & ~start_q;
  assign stop_e   = stop & ~stop_q;
  assign period   = level == 2'd0 ? 26'(P0) : level == 2'd1 ? 26'(P1) : level == 2'd2 ? 26'(P2) : 26'(P3);
  assign term     = cnt >= period;
  assign step_cnt = term ? 26'd1 : cnt + 26'd1;
  assign running  = state == RUN;
  assign paused   = state == PAUSE;
  // Resuming from PAUSE takes a normal counting step on the resume cycle
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tick_n    = 1'b0;
    clk_out_n = clk_out;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        clk_out_n = 1'b0;
        if (start_e && !stop_e) begin
          state_n = RUN;
          cnt_n   = 26'd1;
        end
      end
      RUN: begin
        if (stop_e) state_n = PAUSE;
        else if (acc_e) cnt_n = 26'd1;
        else begin
          tick_n    = term;
          cnt_n     = step_cnt;
          clk_out_n = clk_out ^ term;
        end
      end
      PAUSE: begin
        if (stop_e) begin
          state_n   = IDLE;
          cnt_n     = '0;
          clk_out_n = 1'b0;
        end else if (start_e) begin
          state_n   = RUN;
          tick_n    = term;
          cnt_n     = step_cnt;
          clk_out_n = clk_out ^ term;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // Edge registers reset high so inputs held across reset release give no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      level   <= 2'd0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      acc_q   <= 1'b1;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      level   <= level + {1'b0, acc_e};
      tick    <= tick_n;
      clk_out <= clk_out_n;
      acc_q   <= acc;
      start_q <= start;
      stop_q  <= stop;
    end
  end
endmodule

// File: tb/tb_pulse_rate_ctrl.sv
// tb_pulse_rate_ctrl: directed checks of run/pause/idle, tick timing, level stepping and reset
module tb_pulse_rate_ctrl;
  logic clk = 1'b0, rst = 1'b1, acc = 1'b0, start = 1'b0, stop = 1'b0;
  logic tick, clk_out, running, paused;
  logic [1:0] level;
  int tests = 0, fails = 0;

  pulse_rate_ctrl #(.P0(8), .P1(6), .P2(4), .P3(2)) dut (
    .clk(clk), .rst(rst), .acc(acc), .start(start), .stop(stop),
    .tick(tick), .clk_out(clk_out), .level(level), .running(running), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic a, input logic s, input logic p);
    acc = a; start = s; stop = p;
    step(1);
    acc = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_tick(input string tag, input int exp);
    int c = 0;
    do begin
      step(1);
      c++;
    end while (!tick && c < 40);
    chk(tag, c, exp);
  endtask

  initial begin
    step(3);
    chk("rst_running", running, 0);
    chk("rst_paused", paused, 0);
    chk("rst_level", level, 0);
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    rst = 1'b0;
    step(1);
    // Basic run at level 0
    pulse(0, 1, 0);
    chk("run_after_start", running, 1);
    wait_tick("tick1_delay", 8);
    chk("clk_out_1", clk_out, 1);
    wait_tick("tick2_delay", 8);
    chk("clk_out_2", clk_out, 0);
    wait_tick("tick3_delay", 8);
    chk("clk_out_3", clk_out, 1);
    step(1);
    chk("tick_one_cycle", tick, 0);
    pulse(0, 0, 1);
    chk("pause_a", paused, 1);
    step(1);
    pulse(0, 0, 1);
    chk("idle_a_clk_out", clk_out, 0);
    chk("idle_a_running", running, 0);
    step(1);
    // Level stepping in IDLE
    for (int i = 1; i <= 4; i++) begin
      pulse(1, 0, 0);
      chk($sformatf("idle_level_%0d", i), level, i % 4);
      chk("idle_no_tick", tick, 0);
      chk("idle_no_run", running, 0);
      step(1);
    end
    // Pause with counter at 5, then resume
    pulse(0, 1, 0);
    step(4);
    pulse(0, 0, 1);
    chk("pause_paused", paused, 1);
    chk("pause_running", running, 0);
    step(1);
    pulse(0, 1, 0);
    chk("resume_running", running, 1);
    wait_tick("resume_tick_delay", 3);
    chk("resume_clk_out", clk_out, 1);
    pulse(0, 0, 1);
    chk("pause_b", paused, 1);
    step(1);
    pulse(0, 0, 1);
    chk("idle_b_clk_out", clk_out, 0);
    chk("idle_b_paused", paused, 0);
    chk("idle_b_running", running, 0);
    step(1);
    // acc at terminal count suppresses the tick and reloads
    pulse(0, 1, 0);
    step(7);
    pulse(1, 0, 0);
    chk("acc_term_no_tick", tick, 0);
    chk("acc_term_level", level, 1);
    wait_tick("acc_next_tick", 6);
    // Simultaneous start and stop
    pulse(0, 1, 1);
    chk("both_run_paused", paused, 1);
    chk("both_run_running", running, 0);
    step(1);
    pulse(0, 0, 1);
    chk("to_idle_c", paused, 0);
    step(1);
    pulse(0, 1, 1);
    chk("both_idle_running", running, 0);
    chk("both_idle_paused", paused, 0);
    step(1);
    // Reset mid-run at level 2 with start held high
    pulse(1, 0, 0);
    chk("level_2", level, 2);
    step(1);
    pulse(0, 1, 0);
    step(2);
    start = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_running", running, 0);
    chk("async_level", level, 0);
    chk("async_tick", tick, 0);
    chk("async_clk_out", clk_out, 0);
    step(2);
    rst = 1'b0;
    step(3);
    chk("held_start_no_run", running, 0);
    start = 1'b0;
    step(1);
    pulse(0, 1, 0);
    chk("restart_running", running, 1);
    wait_tick("restart_tick", 8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
